// File: rtl/udm_pkg.sv
// Shared constants and types for the UDM host-to-bus command path.
package udm_pkg;

   localparam int unsigned DEF_ADDR_W = 32;
   localparam int unsigned DEF_DATA_W = 32;
   localparam int unsigned BYTES_A    = DEF_ADDR_W / 8;
   localparam int unsigned BYTES_D    = DEF_DATA_W / 8;

   localparam logic [7:0] CMD_WR_INC       = 8'h81;
   localparam logic [7:0] CMD_RD_INC       = 8'h82;
   localparam logic [7:0] CMD_WR_FIX       = 8'h83;
   localparam logic [7:0] CMD_RD_FIX       = 8'h84;
   localparam logic [7:0] CMD_RST_ASSERT   = 8'h85;
   localparam logic [7:0] CMD_RST_DEASSERT = 8'h86;

   localparam logic [7:0] STATUS_OK      = 8'h00;
   localparam logic [7:0] STATUS_TIMEOUT = 8'h01;

   typedef enum logic [3:0] {
      StIdle,
      StAddr,
      StLen,
      StWdata,
      StBusReq,
      StBusResp,
      StTxData,
      StTxWait,
      StStatus,
      StStatusWait
   } state_e;

endpackage

// File: rtl/udm_xfer_engine_if.sv
// System-bus request/response bundle driven by the UDM transfer engine.
interface udm_xfer_engine_if
   import udm_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned DATA_W = DEF_DATA_W
);
   logic                req;
   logic                ack;
   logic                we;
   logic [ADDR_W-1:0]   addr;
   logic [DATA_W/8-1:0] be;
   logic [DATA_W-1:0]   wdata;
   logic                resp;
   logic [DATA_W-1:0]   rdata;

   modport master (output req, we, addr, be, wdata, input ack, resp, rdata);
   modport slave (input req, we, addr, be, wdata, output ack, resp, rdata);
endinterface

// File: rtl/udm_timeout_cnt.sv
// Phase watchdog: counts enabled cycles, expired flags the Limit-th cycle of a phase.
module udm_timeout_cnt #(
   parameter int unsigned Limit = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   localparam int unsigned W = $clog2(Limit + 1);
   localparam logic [W-1:0] Last = W'(Limit - 1);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt_q <= '0;
      end else if (enable && !expired) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign expired = enable && (cnt_q == Last);
endmodule

// File: rtl/udm_xfer_engine.sv
// UART-byte command engine: parses host frames into bus bursts and answers with data and status.
module udm_xfer_engine
   import udm_pkg::*;
#(
   parameter int unsigned ADDR_W      = BYTES_A * 8,
   parameter int unsigned DATA_W      = BYTES_D * 8,
   parameter int unsigned LEN_W       = 16,
   parameter int unsigned BUS_TIMEOUT = 1024 * 1024 * 100
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       rx_done_tick_i,
   input  logic [7:0] rx_din_bi,
   output logic [7:0] tx_dout_bo,
   output logic       tx_start_o,
   input  logic       tx_done_tick_i,
   output logic       rst_o,
   udm_xfer_engine_if.master bus,
   output logic       busy_o
);
   localparam int unsigned NBA = ADDR_W / 8;
   localparam int unsigned NBD = DATA_W / 8;
   localparam int unsigned NBL = LEN_W / 8;

   state_e            state_q;
   logic [7:0]        cmd_q, cnt_q, tx_dout_q, buf_q;
   logic [ADDR_W-1:0] addr_q, addr_nxt;
   logic [LEN_W-1:0]  len_q, len_new;
   logic [DATA_W-1:0] data_q;
   logic              err_q, rst_q, tx_start_q, req_q, we_q, buf_vld_q;

   logic              inc, is_wr, last_word, byte_vld, tmo_en, tmo_clr, expired;
   logic [7:0]        byte_in;
   logic [ADDR_W+7:0] addr_sh;
   logic [LEN_W+7:0]  len_sh;
   logic [DATA_W+7:0] data_sh;

   always_comb begin
      inc       = (cmd_q == CMD_WR_INC) || (cmd_q == CMD_RD_INC);
      is_wr     = (cmd_q == CMD_WR_INC) || (cmd_q == CMD_WR_FIX);
      last_word = (len_q == LEN_W'(1));
      byte_vld  = buf_vld_q || rx_done_tick_i;
      byte_in   = buf_vld_q ? buf_q : rx_din_bi;
      // LSB-first fields: shift each new byte in from the top
      addr_sh   = {rx_din_bi, addr_q};
      len_sh    = {rx_din_bi, len_q};
      data_sh   = {byte_in, data_q};
      len_new   = len_sh[LEN_W+7:8];
      addr_nxt  = inc ? addr_q + ADDR_W'(NBD) : addr_q;
      tmo_en    = (state_q == StBusReq) || (state_q == StBusResp);
      tmo_clr   = !tmo_en || ((state_q == StBusReq) && bus.ack);
   end

   udm_timeout_cnt #(
      .Limit(BUS_TIMEOUT)
   ) u_tmo (
      .clk    (clk_i),
      .rst    (rst_i),
      .clear  (tmo_clr),
      .enable (tmo_en),
      .expired(expired)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= StIdle;
         cmd_q      <= '0;
         cnt_q      <= '0;
         tx_dout_q  <= '0;
         buf_q      <= '0;
         addr_q     <= '0;
         len_q      <= '0;
         data_q     <= '0;
         err_q      <= 1'b0;
         rst_q      <= 1'b0;
         tx_start_q <= 1'b0;
         req_q      <= 1'b0;
         we_q       <= 1'b0;
         buf_vld_q  <= 1'b0;
      end else begin
         tx_start_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               buf_vld_q <= 1'b0;
               if (rx_done_tick_i) begin
                  case (rx_din_bi)
                     CMD_WR_INC, CMD_RD_INC, CMD_WR_FIX, CMD_RD_FIX: begin
                        cmd_q   <= rx_din_bi;
                        cnt_q   <= '0;
                        err_q   <= 1'b0;
                        state_q <= StAddr;
                     end
                     CMD_RST_ASSERT: begin
                        rst_q   <= 1'b1;
                        err_q   <= 1'b0;
                        state_q <= StStatus;
                     end
                     CMD_RST_DEASSERT: begin
                        rst_q   <= 1'b0;
                        err_q   <= 1'b0;
                        state_q <= StStatus;
                     end
                     default: ;
                  endcase
               end
            end
            StAddr: if (rx_done_tick_i) begin
               addr_q <= addr_sh[ADDR_W+7:8];
               if (cnt_q == 8'(NBA - 1)) begin
                  cnt_q   <= '0;
                  state_q <= StLen;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            StLen: if (rx_done_tick_i) begin
               len_q <= len_new;
               if (cnt_q == 8'(NBL - 1)) begin
                  len_q <= (len_new == '0) ? LEN_W'(1) : len_new;
                  cnt_q <= '0;
                  if (is_wr) begin
                     state_q <= StWdata;
                  end else begin
                     state_q <= StBusReq;
                     req_q   <= 1'b1;
                     we_q    <= 1'b0;
                  end
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            StWdata: if (byte_vld) begin
               data_q    <= data_sh[DATA_W+7:8];
               // A byte arriving while the buffer drains takes its place
               buf_vld_q <= buf_vld_q && rx_done_tick_i;
               buf_q     <= rx_din_bi;
               if (cnt_q == 8'(NBD - 1)) begin
                  cnt_q <= '0;
                  if (err_q) begin
                     len_q  <= len_q - 1'b1;
                     addr_q <= addr_nxt;
                     if (last_word) state_q <= StStatus;
                  end else begin
                     state_q <= StBusReq;
                     req_q   <= 1'b1;
                     we_q    <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            StBusReq: begin
               if (we_q && rx_done_tick_i && !buf_vld_q) begin
                  buf_q     <= rx_din_bi;
                  buf_vld_q <= 1'b1;
               end
               if (bus.ack || expired) begin
                  req_q <= 1'b0;
                  if (!bus.ack) err_q <= 1'b1;
                  if (we_q) begin
                     len_q   <= len_q - 1'b1;
                     addr_q  <= addr_nxt;
                     state_q <= last_word ? StStatus : StWdata;
                  end else if (bus.ack) begin
                     state_q <= StBusResp;
                  end else begin
                     data_q  <= '0;
                     state_q <= StTxData;
                  end
               end
            end
            StBusResp: begin
               if (bus.resp) begin
                  data_q  <= bus.rdata;
                  state_q <= StTxData;
               end else if (expired) begin
                  err_q   <= 1'b1;
                  data_q  <= '0;
                  state_q <= StTxData;
               end
            end
            StTxData: begin
               tx_start_q <= 1'b1;
               tx_dout_q  <= data_q[7:0];
               data_q     <= data_q >> 8;
               cnt_q      <= cnt_q + 8'd1;
               state_q    <= StTxWait;
            end
            StTxWait: if (tx_done_tick_i) begin
               if (cnt_q == 8'(NBD)) begin
                  cnt_q  <= '0;
                  len_q  <= len_q - 1'b1;
                  addr_q <= addr_nxt;
                  if (last_word) begin
                     state_q <= StStatus;
                  end else if (err_q) begin
                     data_q  <= '0;
                     state_q <= StTxData;
                  end else begin
                     state_q <= StBusReq;
                     req_q   <= 1'b1;
                     we_q    <= 1'b0;
                  end
               end else begin
                  state_q <= StTxData;
               end
            end
            StStatus: begin
               tx_start_q <= 1'b1;
               tx_dout_q  <= err_q ? STATUS_TIMEOUT : STATUS_OK;
               state_q    <= StStatusWait;
            end
            StStatusWait: if (tx_done_tick_i) begin
               err_q   <= 1'b0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign tx_dout_bo = tx_dout_q;
   assign tx_start_o = tx_start_q;
   assign rst_o      = rst_q;
   assign bus.req    = req_q;
   assign bus.we     = we_q;
   assign bus.addr   = addr_q;
   assign bus.be     = '1;
   assign bus.wdata  = data_q;
   assign busy_o     = (state_q != StIdle);
endmodule

// File: tb/tb_udm_xfer_engine.sv
// Scoreboard bench for udm_xfer_engine: 32/32 and 16/64 instances share one stimulus/check path.
module tb_udm_xfer_engine;
   typedef struct {
      logic        we;
      logic [63:0] addr;
      logic [63:0] data;
   } bus_t;

   logic        clk = 1'b0;
   logic        rst, sel, rx_tick, tx_done, ack, resp, slave_en, rd_pend;
   logic [7:0]  rx_byte;
   logic [63:0] rdata;
   int          checks = 0, failures = 0, wait_cnt = 0, req_rises = 0;
   logic        req_prev = 1'b0, acked = 1'b0;

   bus_t        exp_bus[$];
   logic [7:0]  exp_tx[$];
   logic [63:0] rd_q[$];

   always #5 clk = ~clk;

   udm_xfer_engine_if #(.ADDR_W(32), .DATA_W(32)) bus32 ();
   udm_xfer_engine_if #(.ADDR_W(16), .DATA_W(64)) bus64 ();

   logic       rx32, rx64, tx_start32, tx_start64, rst_o32, rst_o64, busy32, busy64;
   logic [7:0] tx_dout32, tx_dout64;
   assign rx32 = rx_tick & ~sel;
   assign rx64 = rx_tick & sel;

   udm_xfer_engine #(.ADDR_W(32), .DATA_W(32), .LEN_W(16), .BUS_TIMEOUT(16)) dut32 (
      .clk_i(clk), .rst_i(rst), .rx_done_tick_i(rx32), .rx_din_bi(rx_byte),
      .tx_dout_bo(tx_dout32), .tx_start_o(tx_start32), .tx_done_tick_i(tx_done),
      .rst_o(rst_o32), .bus(bus32), .busy_o(busy32));

   udm_xfer_engine #(.ADDR_W(16), .DATA_W(64), .LEN_W(16), .BUS_TIMEOUT(16)) dut64 (
      .clk_i(clk), .rst_i(rst), .rx_done_tick_i(rx64), .rx_din_bi(rx_byte),
      .tx_dout_bo(tx_dout64), .tx_start_o(tx_start64), .tx_done_tick_i(tx_done),
      .rst_o(rst_o64), .bus(bus64), .busy_o(busy64));

   assign bus32.ack = ack;
   assign bus64.ack = ack;
   assign bus32.resp = resp;
   assign bus64.resp = resp;
   assign bus32.rdata = rdata[31:0];
   assign bus64.rdata = rdata;

   logic        m_req, m_we, m_tx_start, m_busy, m_rst;
   logic [63:0] m_addr, m_wdata;
   logic [7:0]  m_be, m_tx_dout;
   assign m_req      = sel ? bus64.req : bus32.req;
   assign m_we       = sel ? bus64.we : bus32.we;
   assign m_addr     = sel ? 64'(bus64.addr) : 64'(bus32.addr);
   assign m_wdata    = sel ? bus64.wdata : 64'(bus32.wdata);
   assign m_be       = sel ? bus64.be : 8'(bus32.be);
   assign m_tx_start = sel ? tx_start64 : tx_start32;
   assign m_tx_dout  = sel ? tx_dout64 : tx_dout32;
   assign m_busy     = sel ? busy64 : busy32;
   assign m_rst      = sel ? rst_o64 : rst_o32;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic fail_evt(input string name);
      checks++;
      failures++;
      $display("FAIL %s", name);
   endtask

   task automatic push_bus(input logic we, input logic [63:0] addr, input logic [63:0] data);
      bus_t e;
      e.we = we;
      e.addr = addr;
      e.data = data;
      exp_bus.push_back(e);
   endtask

   task automatic push_tx_word(input logic [63:0] w, input int nbytes);
      for (int i = 0; i < nbytes; i++) exp_tx.push_back(8'(w >> (8 * i)));
   endtask

   task automatic send_byte(input logic [7:0] b);
      repeat (4) @(negedge clk);
      rx_byte = b;
      rx_tick = 1'b1;
      @(negedge clk);
      rx_tick = 1'b0;
   endtask

   task automatic send_word(input logic [63:0] w, input int nbytes);
      for (int i = 0; i < nbytes; i++) send_byte(8'(w >> (8 * i)));
   endtask

   task automatic send_hdr(input logic [7:0] cmd, input logic [63:0] addr, input logic [15:0] len);
      send_byte(cmd);
      send_word(addr, sel ? 2 : 4);
      send_word(64'(len), 2);
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while ((m_busy || exp_tx.size() != 0) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 3000) fail_evt({name, "_no_completion"});
      chk({name, "_tx_left"}, 64'(exp_tx.size()), 64'd0);
      chk({name, "_bus_left"}, 64'(exp_bus.size()), 64'd0);
      repeat (4) @(negedge clk);
   endtask

   // Bus slave and bus-side scoreboard check
   initial begin
      bus_t e;
      ack = 1'b0;
      resp = 1'b0;
      rdata = '0;
      rd_pend = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (acked) chk("req_drop_after_ack", 64'(m_req), 64'd0);
         acked = 1'b0;
         ack = 1'b0;
         resp = 1'b0;
         if (rd_pend) begin
            resp = 1'b1;
            rdata = (rd_q.size() != 0) ? rd_q.pop_front() : 64'd0;
            rd_pend = 1'b0;
         end else if (m_req && slave_en) begin
            if (wait_cnt == 4) begin
               ack = 1'b1;
               acked = 1'b1;
               wait_cnt = 0;
               if (exp_bus.size() == 0) begin
                  fail_evt("unexpected_bus_request");
               end else begin
                  e = exp_bus.pop_front();
                  chk("bus_we", 64'(m_we), 64'(e.we));
                  chk("bus_addr", m_addr, e.addr);
                  chk("bus_be", 64'(m_be), sel ? 64'hFF : 64'h0F);
                  if (e.we) chk("bus_wdata", m_wdata, e.data);
               end
               if (!m_we) rd_pend = 1'b1;
            end else begin
               wait_cnt++;
            end
         end else begin
            wait_cnt = 0;
         end
      end
   end

   // UART tx model and tx-side scoreboard check
   initial begin
      tx_done = 1'b0;
      forever begin
         @(negedge clk);
         if (m_tx_start) begin
            if (exp_tx.size() == 0) fail_evt($sformatf("unexpected_tx got 0x%0h", m_tx_dout));
            else chk("tx_byte", 64'(m_tx_dout), 64'(exp_tx.pop_front()));
            repeat (3) begin
               @(negedge clk);
               if (m_tx_start) fail_evt("tx_start_before_done");
            end
            tx_done = 1'b1;
            @(negedge clk);
            tx_done = 1'b0;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (m_req && !req_prev) req_rises++;
         req_prev = m_req;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog_expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst = 1'b1;
      sel = 1'b0;
      rx_tick = 1'b0;
      rx_byte = '0;
      slave_en = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_tx_start", 64'(tx_start32), 64'd0);
      chk("rst_tx_dout", 64'(tx_dout32), 64'd0);
      chk("rst_rst_o", 64'(rst_o32), 64'd0);
      chk("rst_busy", 64'(busy32), 64'd0);
      chk("rst_req", 64'(bus32.req), 64'd0);
      chk("rst_we", 64'(bus32.we), 64'd0);
      chk("rst_addr", 64'(bus32.addr), 64'd0);
      chk("rst_wdata", 64'(bus32.wdata), 64'd0);
      chk("rst_req64", 64'(bus64.req), 64'd0);
      chk("rst_busy64", 64'(busy64), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // Stray byte, then reset commands
      send_byte(8'h42);
      repeat (10) @(negedge clk);
      chk("stray_busy", 64'(m_busy), 64'd0);
      exp_tx.push_back(8'h00);
      send_byte(8'h85);
      chk("rst_assert", 64'(m_rst), 64'd1);
      wait_done("rst_assert");
      exp_tx.push_back(8'h00);
      send_byte(8'h86);
      chk("rst_deassert", 64'(m_rst), 64'd0);
      wait_done("rst_deassert");

      // WR_INC 32-bit, two words
      push_bus(1'b1, 64'h1000, 64'h11223344);
      push_bus(1'b1, 64'h1004, 64'h55667788);
      exp_tx.push_back(8'h00);
      send_hdr(8'h81, 64'h1000, 16'd2);
      send_word(64'h11223344, 4);
      send_word(64'h55667788, 4);
      chk("wr_req_latency", 64'(m_req), 64'd1);
      wait_done("wr_inc32");

      // RD_FIX 32-bit, three words
      rd_q.push_back(64'hA5A5A5A5);
      rd_q.push_back(64'h1);
      rd_q.push_back(64'h2);
      repeat (3) push_bus(1'b0, 64'h2000, 64'h0);
      exp_tx = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h01, 8'h00, 8'h00, 8'h00,
                 8'h02, 8'h00, 8'h00, 8'h00, 8'h00};
      send_hdr(8'h84, 64'h2000, 16'd3);
      wait_done("rd_fix32");

      // Address wrap
      push_bus(1'b1, 64'hFFFFFFFC, 64'hDEADBEEF);
      push_bus(1'b1, 64'h00000000, 64'h01020304);
      exp_tx.push_back(8'h00);
      send_hdr(8'h81, 64'hFFFFFFFC, 16'd2);
      send_word(64'hDEADBEEF, 4);
      send_word(64'h01020304, 4);
      wait_done("addr_wrap");

      // Timeout on a 2-word read
      slave_en = 1'b0;
      req_rises = 0;
      repeat (8) exp_tx.push_back(8'h00);
      exp_tx.push_back(8'h01);
      send_hdr(8'h82, 64'h3000, 16'd2);
      n = 0;
      while (m_req && n < 100) begin
         n++;
         @(negedge clk);
      end
      chk("timeout_req_cycles", 64'(n), 64'd16);
      wait_done("timeout");
      chk("timeout_req_count", 64'(req_rises), 64'd1);
      slave_en = 1'b1;

      // Reset mid-burst
      exp_tx.push_back(8'h00);
      send_byte(8'h85);
      wait_done("pre_midrst");
      req_rises = 0;
      send_hdr(8'h81, 64'h1000, 16'd1);
      send_byte(8'h44);
      send_byte(8'h33);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_rst_o", 64'(m_rst), 64'd0);
      chk("midrst_busy", 64'(m_busy), 64'd0);
      repeat (30) @(negedge clk);
      chk("midrst_req_count", 64'(req_rises), 64'd0);
      exp_tx.push_back(8'h00);
      send_byte(8'h85);
      chk("midrst_assert", 64'(m_rst), 64'd1);
      wait_done("midrst_assert");
      exp_tx.push_back(8'h00);
      send_byte(8'h86);
      wait_done("midrst_deassert");

      // Width variant: ADDR_W=16, DATA_W=64
      sel = 1'b1;
      @(negedge clk);
      push_bus(1'b1, 64'h1000, 64'h8877665544332211);
      push_bus(1'b1, 64'h1008, 64'h0123456789ABCDEF);
      exp_tx.push_back(8'h00);
      send_hdr(8'h81, 64'h1000, 16'd2);
      send_word(64'h8877665544332211, 8);
      send_word(64'h0123456789ABCDEF, 8);
      chk("wr64_req_latency", 64'(m_req), 64'd1);
      wait_done("wr_inc64");

      rd_q.push_back(64'hA5A5A5A5A5A5A5A5);
      rd_q.push_back(64'h1);
      rd_q.push_back(64'h2);
      repeat (3) push_bus(1'b0, 64'h2000, 64'h0);
      push_tx_word(64'hA5A5A5A5A5A5A5A5, 8);
      push_tx_word(64'h1, 8);
      push_tx_word(64'h2, 8);
      exp_tx.push_back(8'h00);
      send_hdr(8'h84, 64'h2000, 16'd3);
      wait_done("rd_fix64");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
